fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_scan_controller.sv | 129 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// ============================================================================
// Module   : fnd_scan_controller
// Brief    : Multiplexed 7-segment (FND) scan driver with per-frame snapshot,
//            decimal points, forced blanking and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 100000,
  parameter int HEX_EN      = 0,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic                  i_En,
  output logic [7:0]            o_font,
  output logic [DIGITS-1:0]     o_digit,
  output logic                  o_frame
);

  localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]   c_idx_max   = c_idx_w'(DIGITS - 1);

  logic [c_presc_w-1:0] r_presc;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_first;
  logic [4*DIGITS-1:0]  r_val;
  logic [DIGITS-1:0]    r_dp;
  logic [DIGITS-1:0]    r_blank;

  logic                 w_tick;
  logic                 w_load;
  logic [3:0]           w_nibs [DIGITS];
  logic [DIGITS-1:0]    w_upper_nz;
  logic [DIGITS-1:0]    w_sel;
  logic [3:0]           w_nib;
  logic [7:0]           w_font_raw;
  logic                 w_seg_blank;
  logic [7:0]           w_font;

  assign w_tick = (r_presc == c_presc_max);
  // r_first forces a snapshot in the first cycle out of reset
  assign w_load = r_first | (w_tick & (r_idx == c_idx_max));

  genvar d;
  generate
    for (d = 0; d < DIGITS; d++) begin : g_digit
      assign w_nibs[d]      = r_val[4*d +: 4];
      assign w_upper_nz[d]  = |r_val[4*DIGITS-1:4*d];
      assign w_sel[d]       = (r_idx == c_idx_w'(d));
    end
  endgenerate

  assign w_nib = w_nibs[r_idx];

  always_comb begin
    w_font_raw = 8'hff;
    case (w_nib)
      4'h0: w_font_raw = 8'hc0;
      4'h1: w_font_raw = 8'hf9;
      4'h2: w_font_raw = 8'ha4;
      4'h3: w_font_raw = 8'hb0;
      4'h4: w_font_raw = 8'h99;
      4'h5: w_font_raw = 8'h92;
      4'h6: w_font_raw = 8'h82;
      4'h7: w_font_raw = 8'hf8;
      4'h8: w_font_raw = 8'h80;
      4'h9: w_font_raw = 8'h90;
      4'ha: w_font_raw = 8'h88;
      4'hb: w_font_raw = 8'h83;
      4'hc: w_font_raw = 8'hc6;
      4'hd: w_font_raw = 8'ha1;
      4'he: w_font_raw = 8'h86;
      4'hf: w_font_raw = 8'h8e;
      default: w_font_raw = 8'hff;
    endcase
    if ((HEX_EN == 0) && (w_nib > 4'd9)) begin
      w_font_raw = 8'hff;
    end
  end

  // Digit 0 is never a leading zero, so a plain 0 always stays visible
  assign w_seg_blank = r_blank[r_idx] |
                       ((LZ_SUPPRESS != 0) && (r_idx != '0) && !w_upper_nz[r_idx]);
  assign w_font      = {~r_dp[r_idx], w_seg_blank ? 7'h7f : w_font_raw[6:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
      r_val   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      o_frame <= 1'b0;
      o_font  <= 8'hff;
      o_digit <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
      end
      r_first <= 1'b0;
      if (w_load) begin
        r_val   <= i_value;
        r_dp    <= i_dp;
        r_blank <= i_blank;
      end
      o_frame <= w_load;
      if (i_En) begin
        o_font  <= w_font;
        o_digit <= ~w_sel;
      end else begin
        o_font  <= 8'hff;
        o_digit <= '1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: three instances (plain, hex+leading-zero, single digit)
// checked every cycle against an arithmetic model, plus hand-computed pins.
`default_nettype none

module tb_fnd_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp, blank;
  logic        en;

  logic [7:0] font_a, font_b, font_c;
  logic [3:0] digit_a, digit_b;
  logic       digit_c;
  logic       frame_a, frame_b, frame_c;

  int n_vec = 0;
  int n_err = 0;

  fnd_scan_controller #(.DIGITS(4), .CLK_DIV(4), .HEX_EN(0), .LZ_SUPPRESS(0)) u_a (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_dp(dp), .i_blank(blank),
    .i_En(en), .o_font(font_a), .o_digit(digit_a), .o_frame(frame_a));

  fnd_scan_controller #(.DIGITS(4), .CLK_DIV(4), .HEX_EN(1), .LZ_SUPPRESS(1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_dp(dp), .i_blank(blank),
    .i_En(en), .o_font(font_b), .o_digit(digit_b), .o_frame(frame_b));

  fnd_scan_controller #(.DIGITS(1), .CLK_DIV(2), .HEX_EN(0), .LZ_SUPPRESS(0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_value(value[3:0]), .i_dp(dp[0:0]), .i_blank(blank[0:0]),
    .i_En(en), .o_font(font_c), .o_digit(digit_c), .o_frame(frame_c));

  localparam logic [7:0] SEG [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

  function automatic logic [7:0] seg_of(input logic [3:0] v, input bit hex, input bit dpl, input bit blk);
    logic [7:0] f;
    f = (v > 4'd9 && !hex) ? 8'hff : SEG[v];
    if (blk) f[6:0] = 7'h7f;
    if (dpl) f[7] = 1'b0;
    return f;
  endfunction

  function automatic logic [7:0] digit_font(input logic [15:0] v, input logic [3:0] dpv,
                                            input logic [3:0] bl, input int d, input bit hex, input bit lz);
    bit lzb;
    lzb = lz && (d > 0) && ((v >> (4*d)) == 16'h0);
    return seg_of(v[4*d +: 4], hex, dpv[d], bl[d] || lzb);
  endfunction

  // Model: k = clock edges since reset release; slot = k / CLK_DIV, frame = DIGITS slots
  int         k;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  m_val_c;
  logic        m_dp_c, m_blank_c;
  logic [7:0]  exp_font_a, exp_font_b, exp_font_c;
  logic [3:0]  exp_digit;
  logic        exp_digit_c, exp_frame, exp_frame_c;

  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
      m_val <= '0; m_dp <= '0; m_blank <= '0;
      m_val_c <= '0; m_dp_c <= 1'b0; m_blank_c <= 1'b0;
      exp_font_a <= 8'hff; exp_font_b <= 8'hff; exp_font_c <= 8'hff;
      exp_digit <= 4'hf; exp_digit_c <= 1'b1;
      exp_frame <= 1'b0; exp_frame_c <= 1'b0;
    end else begin
      k <= k + 1;
      exp_frame <= (k == 0) || ((k + 1) % 16 == 0);
      if ((k == 0) || ((k + 1) % 16 == 0)) begin
        m_val <= value; m_dp <= dp; m_blank <= blank;
      end
      exp_digit  <= en ? ~(4'b0001 << ((k / 4) % 4)) : 4'hf;
      exp_font_a <= en ? digit_font(m_val, m_dp, m_blank, (k / 4) % 4, 1'b0, 1'b0) : 8'hff;
      exp_font_b <= en ? digit_font(m_val, m_dp, m_blank, (k / 4) % 4, 1'b1, 1'b1) : 8'hff;
      exp_frame_c <= (k == 0) || ((k + 1) % 2 == 0);
      if ((k == 0) || ((k + 1) % 2 == 0)) begin
        m_val_c <= value[3:0]; m_dp_c <= dp[0]; m_blank_c <= blank[0];
      end
      exp_digit_c <= !en;
      exp_font_c  <= en ? digit_font({12'h0, m_val_c}, {3'b0, m_dp_c}, {3'b0, m_blank_c}, 0, 1'b0, 1'b0)
                        : 8'hff;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("font_a",  font_a, exp_font_a);
      chk("font_b",  font_b, exp_font_b);
      chk("font_c",  font_c, exp_font_c);
      chk("digit_a", {4'h0, digit_a}, {4'h0, exp_digit});
      chk("digit_b", {4'h0, digit_b}, {4'h0, exp_digit});
      chk("digit_c", {7'h0, digit_c}, {7'h0, exp_digit_c});
      chk("frame_a", {7'h0, frame_a}, {7'h0, exp_frame});
      chk("frame_b", {7'h0, frame_b}, {7'h0, exp_frame});
      chk("frame_c", {7'h0, frame_c}, {7'h0, exp_frame_c});
    end
  endtask

  task automatic wait_frame();
    int c;
    c = 0;
    do begin
      run(1);
      c++;
    end while (!exp_frame && c < 40);
    if (!exp_frame) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_frame: no frame within %0d cycles", c);
    end
  endtask

  initial begin
    rst = 1'b1; value = 16'h1234; dp = 4'h0; blank = 4'h0; en = 1'b1;
    run(3);
    chk("reset_font", font_a, 8'hff);
    chk("reset_digit", {4'h0, digit_a}, 8'h0f);
    chk("reset_frame", {7'h0, frame_a}, 8'h00);

    // Scan of 1234 from reset release
    rst = 1'b0;
    run(1);
    chk("first_frame", {7'h0, frame_a}, 8'h01);
    chk("first_digit", {4'h0, digit_a}, 8'h0e);
    chk("first_font", font_a, 8'hc0);
    chk("c_first_font", font_c, 8'hc0);
    run(1);
    chk("d0_font", font_a, 8'h99);
    chk("frame_once", {7'h0, frame_a}, 8'h00);
    chk("c_font", font_c, 8'h99);
    chk("c_frame_tick", {7'h0, frame_c}, 8'h01);
    run(3);
    chk("d1_font", font_a, 8'hb0);
    chk("d1_digit", {4'h0, digit_a}, 8'h0d);

    // Mid-frame change must not tear the current frame
    value = 16'h5678;
    run(9);
    chk("d3_old_font", font_a, 8'hf9);
    chk("d3_digit", {4'h0, digit_a}, 8'h07);
    run(2);
    chk("frame2", {7'h0, frame_a}, 8'h01);
    run(1);
    chk("new_d0_font", font_a, 8'h80);

    // Leading-zero suppression
    value = 16'h0050;
    wait_frame(); run(1);
    chk("lz_d0_b", font_b, 8'hc0);
    run(4);
    chk("lz_d1_b", font_b, 8'h92);
    run(4);
    chk("lz_d2_b", font_b, 8'hff);
    chk("nolz_d2_a", font_a, 8'hc0);
    run(4);
    chk("lz_d3_b", font_b, 8'hff);
    value = 16'h0000;
    wait_frame(); run(1);
    chk("zero_d0_b", font_b, 8'hc0);
    run(4);
    chk("zero_d1_b", font_b, 8'hff);

    // Decimal point and forced blank
    value = 16'h0009; dp = 4'b0010; blank = 4'b0001;
    wait_frame(); run(1);
    chk("blank_d0_a", font_a, 8'hff);
    run(4);
    chk("dp_d1_a", font_a, 8'h40);
    chk("dp_lz_d1_b", font_b, 8'h7f);

    // Hex rendering versus blanking above 9
    value = 16'h00af; dp = 4'h0; blank = 4'h0;
    wait_frame(); run(1);
    chk("nohex_d0", font_a, 8'hff);
    chk("hex_d0", font_b, 8'h8e);
    run(4);
    chk("nohex_d1", font_a, 8'hff);
    chk("hex_d1", font_b, 8'h88);

    // Display disable keeps scanning underneath
    en = 1'b0;
    run(1);
    chk("dis_font", font_a, 8'hff);
    chk("dis_digit", {4'h0, digit_a}, 8'h0f);
    run(5);
    en = 1'b1;
    run(1);
    chk("reen_digit", {4'h0, digit_a}, 8'h0b);

    // Reset while digit 2 is on
    wait_frame(); run(9);
    chk("slot2_digit", {4'h0, digit_a}, 8'h0b);
    rst = 1'b1;
    run(1);
    chk("mid_rst_font", font_a, 8'hff);
    chk("mid_rst_digit", {4'h0, digit_a}, 8'h0f);
    chk("mid_rst_frame", {7'h0, frame_a}, 8'h00);
    run(2);
    rst = 1'b0;
    run(1);
    chk("restart_frame", {7'h0, frame_a}, 8'h01);
    chk("restart_digit", {4'h0, digit_a}, 8'h0e);
    chk("restart_font", font_a, 8'hc0);
    run(1);
    chk("restart_d0_b", font_b, 8'h8e);
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
